// File: rtl/icache_pkg.sv
// Shared widths, FSM states and tag-entry layout for the i-cache tag controller.
// Address split: {tag[31:9], index[8:5], offset[4:0]}.
package icache_pkg;

   localparam int ADDR_W   = 32;
   localparam int OFFSET_W = 5;
   localparam int INDEX_W  = 4;
   localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;
   localparam int ENTRY_W  = TAG_W + 1;
   localparam int DEPTH    = 1 << INDEX_W;

   typedef enum logic [1:0] {INIT, IDLE, FLUSH} state_t;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
   } tag_entry_t;

   function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
      return addr[OFFSET_W +: INDEX_W];
   endfunction

   function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1 -: TAG_W];
   endfunction

endpackage

// File: rtl/icache_tag_sweep.sv
// Index counter that walks every tag entry once, for the power-up and flush invalidation sweeps.
// Comes out of reset already sweeping; o_done marks the cycle the last index is issued.
module icache_tag_sweep
   import icache_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   output logic               o_active,
   output logic [INDEX_W-1:0] o_idx,
   output logic               o_done
);

   localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(DEPTH - 1);

   logic               r_active;
   logic [INDEX_W-1:0] r_idx;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active <= 1'b1;
         r_idx    <= '0;
      end else if (i_start) begin
         r_active <= 1'b1;
         r_idx    <= '0;
      end else if (r_active) begin
         r_idx <= r_idx + 1'b1;
         if (r_idx == LAST_IDX) r_active <= 1'b0;
      end
   end

   assign o_active = r_active;
   assign o_idx    = r_idx;
   assign o_done   = r_active && (r_idx == LAST_IDX);

endmodule

// File: rtl/icache_tag_ctrl.sv
// Sequences the single-port i-cache tag SRAM: invalidation sweeps, fill writes and fetch lookups,
// with the hit/miss compare done on the SRAM output in the cycle after a lookup is accepted.
module icache_tag_ctrl
   import icache_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               lk_valid,
   input  logic [ADDR_W-1:0]  lk_addr,
   output logic               lk_ready,
   output logic               rsp_valid,
   output logic               rsp_hit,
   output logic [ADDR_W-1:0]  rsp_addr,
   input  logic               fill_valid,
   input  logic [ADDR_W-1:0]  fill_addr,
   output logic               fill_ready,
   input  logic               flush_req,
   output logic               busy,
   output logic               tag_csb,
   output logic               tag_web,
   output logic [INDEX_W-1:0] tag_addr,
   output logic [ENTRY_W-1:0] tag_din,
   input  logic [ENTRY_W-1:0] tag_dout
);

   state_t             r_state;
   logic               w_sweep_active;
   logic               w_sweep_done;
   logic [INDEX_W-1:0] w_sweep_idx;
   logic               w_idle;
   logic               w_flush_go;
   logic               w_fill_go;
   logic               w_lk_go;
   logic               w_cmd;
   logic               w_we;
   logic [INDEX_W-1:0] w_cmd_addr;
   tag_entry_t         w_cmd_din;
   logic [INDEX_W-1:0] r_addr_q;
   tag_entry_t         r_din_q;
   logic               r_rsp_valid;
   logic [ADDR_W-1:0]  r_rsp_addr;
   tag_entry_t         w_dout;

   icache_tag_sweep u_sweep (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (w_flush_go),
      .o_active (w_sweep_active),
      .o_idx    (w_sweep_idx),
      .o_done   (w_sweep_done)
   );

   assign w_idle     = (r_state == IDLE);
   assign busy       = !w_idle;
   assign w_flush_go = w_idle && flush_req;
   assign fill_ready = w_idle && !flush_req;
   assign lk_ready   = fill_ready && !fill_valid;
   assign w_fill_go  = fill_valid && fill_ready;
   assign w_lk_go    = lk_valid && lk_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= INIT;
      end else begin
         case (r_state)
            INIT, FLUSH: if (w_sweep_done) r_state <= IDLE;
            IDLE:        if (flush_req)    r_state <= FLUSH;
            default:     r_state <= INIT;
         endcase
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_cmd      = 1'b0;
      w_we       = 1'b0;
      w_cmd_addr = r_addr_q;
      w_cmd_din  = r_din_q;
      if (w_sweep_active) begin
         w_cmd      = 1'b1;
         w_we       = 1'b1;
         w_cmd_addr = w_sweep_idx;
         w_cmd_din  = '0;
      end else if (w_fill_go) begin
         w_cmd           = 1'b1;
         w_we            = 1'b1;
         w_cmd_addr      = get_index(fill_addr);
         w_cmd_din.valid = 1'b1;
         w_cmd_din.tag   = get_tag(fill_addr);
      end else if (w_lk_go) begin
         w_cmd      = 1'b1;
         w_cmd_addr = get_index(lk_addr);
      end
   end

   // Pins keep their last driven address/data while deselected; the sweep counter is already
   // at index 0 during reset, so only the strobes need masking with rst_n.
   assign tag_csb  = !(w_cmd && rst_n);
   assign tag_web  = !(w_we && rst_n);
   assign tag_addr = w_cmd_addr;
   assign tag_din  = w_cmd_din;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr_q    <= '0;
         r_din_q     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_addr  <= '0;
      end else begin
         if (w_cmd) r_addr_q <= w_cmd_addr;
         if (w_we)  r_din_q  <= w_cmd_din;
         r_rsp_valid <= w_lk_go;
         if (w_lk_go) r_rsp_addr <= lk_addr;
      end
   end

   assign w_dout    = tag_entry_t'(tag_dout);
   assign rsp_valid = r_rsp_valid;
   assign rsp_addr  = r_rsp_addr;
   assign rsp_hit   = r_rsp_valid && w_dout.valid && (w_dout.tag == get_tag(r_rsp_addr));

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Bench for icache_tag_ctrl: behavioural tag SRAM, reference tag model and a response scoreboard.
module tb_icache_tag_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lk_valid, fill_valid, flush_req;
   logic [31:0] lk_addr, fill_addr;
   logic        lk_ready, fill_ready, rsp_valid, rsp_hit, busy;
   logic [31:0] rsp_addr;
   logic        tag_csb, tag_web;
   logic [3:0]  tag_addr;
   logic [23:0] tag_din, tag_dout;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] addr;
      logic        hit;
   } exp_t;

   exp_t        sb_q[$];
   logic        m_valid [16];
   logic [22:0] m_tag   [16];

   always #5 clk = ~clk;

   icache_tag_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lk_valid   (lk_valid),
      .lk_addr    (lk_addr),
      .lk_ready   (lk_ready),
      .rsp_valid  (rsp_valid),
      .rsp_hit    (rsp_hit),
      .rsp_addr   (rsp_addr),
      .fill_valid (fill_valid),
      .fill_addr  (fill_addr),
      .fill_ready (fill_ready),
      .flush_req  (flush_req),
      .busy       (busy),
      .tag_csb    (tag_csb),
      .tag_web    (tag_web),
      .tag_addr   (tag_addr),
      .tag_din    (tag_din),
      .tag_dout   (tag_dout)
   );

   // Tag SRAM: registered inputs, write commits at the edge, dout follows the captured read address.
   logic [23:0] mem [16];
   logic [3:0]  r_ra   = '0;
   logic        seeded = 1'b0;
   always @(posedge clk) begin
      if (!seeded) begin
         for (int i = 0; i < 16; i++) mem[i] <= 24'h800000 | 24'($urandom);
         seeded <= 1'b1;
      end else if (!tag_csb) begin
         if (!tag_web) mem[tag_addr] <= tag_din;
         else          r_ra          <= tag_addr;
      end
   end
   assign tag_dout = mem[r_ra];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: responses are due on the negedge right after the accepting edge.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst_n) begin
         sb_q.delete();
         for (int i = 0; i < 16; i++) m_valid[i] <= 1'b0;
      end else begin
         if (rsp_valid) begin
            if (sb_q.size() == 0) begin
               check("rsp_unexpected", 32'(rsp_valid), 0);
            end else begin
               e = sb_q.pop_front();
               check("rsp_addr", rsp_addr, e.addr);
               check("rsp_hit", 32'(rsp_hit), 32'(e.hit));
            end
         end else if (sb_q.size() != 0) begin
            check("rsp_missing", 32'(rsp_valid), 1);
            sb_q.delete();
         end
         if (flush_req && !busy) begin
            for (int i = 0; i < 16; i++) m_valid[i] <= 1'b0;
         end else if (fill_valid && fill_ready) begin
            m_valid[fill_addr[8:5]] <= 1'b1;
            m_tag[fill_addr[8:5]]   <= fill_addr[31:9];
         end else if (lk_valid && lk_ready) begin
            e.addr = lk_addr;
            e.hit  = m_valid[lk_addr[8:5]] && (m_tag[lk_addr[8:5]] == lk_addr[31:9]);
            sb_q.push_back(e);
         end
      end
   end

   task automatic check_reset(input string tag);
      check({tag, "_busy"},  32'(busy), 1);
      check({tag, "_ready"}, 32'({lk_ready, fill_ready}), 0);
      check({tag, "_rsp"},   32'({rsp_valid, rsp_hit}), 0);
      check({tag, "_raddr"}, rsp_addr, 0);
      check({tag, "_strb"},  32'({tag_csb, tag_web}), 3);
      check({tag, "_taddr"}, 32'(tag_addr), 0);
      check({tag, "_tdin"},  32'(tag_din), 0);
   endtask

   task automatic sweep(input int inject_at, input int stop_at);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("sweep_busy",  32'(busy), 1);
         check("sweep_strb",  32'({tag_csb, tag_web}), 0);
         check("sweep_addr",  32'(tag_addr), i);
         check("sweep_din",   32'(tag_din), 0);
         check("sweep_ready", 32'({lk_ready, fill_ready}), 0);
         if (i == stop_at) return;
         if (i == inject_at) begin
            @(posedge clk); #1; flush_req = 1'b1;
         end else if (i == inject_at + 1) begin
            @(posedge clk); #1; flush_req = 1'b0;
         end
      end
      @(negedge clk);
      check("idle_busy",      32'(busy), 0);
      check("idle_csb",       32'(tag_csb), 1);
      check("idle_addr_hold", 32'(tag_addr), 15);
      check("idle_ready",     32'({lk_ready, fill_ready}), 3);
   endtask

   task automatic lookup(input logic [31:0] a);
      int n = 0;
      @(posedge clk); #1; lk_valid = 1'b1; lk_addr = a;
      @(negedge clk);
      while (!lk_ready && n < 40) begin @(negedge clk); n++; end
      check("lk_accept",  32'(lk_ready), 1);
      check("lk_pins",    32'({tag_csb, tag_web}), 1);
      check("lk_addr_pin", 32'(tag_addr), 32'(a[8:5]));
      @(posedge clk); #1; lk_valid = 1'b0;
   endtask

   task automatic fill(input logic [31:0] a);
      int n = 0;
      @(posedge clk); #1; fill_valid = 1'b1; fill_addr = a;
      @(negedge clk);
      while (!fill_ready && n < 40) begin @(negedge clk); n++; end
      check("fill_accept", 32'(fill_ready), 1);
      check("fill_pins",   32'({tag_csb, tag_web}), 0);
      check("fill_addr",   32'(tag_addr), 32'(a[8:5]));
      check("fill_din",    32'(tag_din), 32'({1'b1, a[31:9]}));
      @(posedge clk); #1; fill_valid = 1'b0;
   endtask

   task automatic fill_then_lookup(input logic [31:0] f, input logic [31:0] l);
      @(posedge clk); #1; fill_valid = 1'b1; fill_addr = f;
      @(negedge clk); check("ftl_fill_rdy", 32'(fill_ready), 1);
      @(posedge clk); #1; fill_valid = 1'b0; lk_valid = 1'b1; lk_addr = l;
      @(negedge clk); check("ftl_lk_rdy", 32'(lk_ready), 1);
      @(posedge clk); #1; lk_valid = 1'b0;
      @(negedge clk); check("ftl_rsp", 32'({rsp_valid, rsp_hit}), 3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] b2b [4];
      b2b = '{32'h0000_1240, 32'h0000_3240, 32'h0000_2080, 32'h0005_6660};
      rst_n = 1'b0; lk_valid = 1'b0; fill_valid = 1'b0; flush_req = 1'b0;
      lk_addr = '0; fill_addr = '0;

      // Power-up sweep.
      repeat (3) @(posedge clk);
      @(negedge clk); check_reset("rst");
      @(posedge clk); #1; rst_n = 1'b1;
      sweep(-1, -1);
      lookup(32'h0000_0000);

      // Fill then lookups on hit and on same-index different-tag.
      fill(32'h0000_1240);
      lookup(32'h0000_1240);
      @(negedge clk); check("lat1_rsp", 32'({rsp_valid, rsp_hit}), 3);
      lookup(32'h0000_3240);

      // Fill and lookup in consecutive cycles, existing and fresh lines.
      fill_then_lookup(32'h0000_1240, 32'h0000_1244);
      fill_then_lookup(32'h0005_6660, 32'h0005_6664);

      // Fill and lookup offered together: fill wins, lookup goes next cycle.
      @(posedge clk); #1;
      fill_valid = 1'b1; fill_addr = 32'h0000_2080; lk_valid = 1'b1; lk_addr = 32'h0000_2080;
      @(negedge clk); check("both_rdy", 32'({fill_ready, lk_ready}), 2);
      @(posedge clk); #1; fill_valid = 1'b0;
      @(negedge clk); check("both_lk_next", 32'(lk_ready), 1);
      @(posedge clk); #1; lk_valid = 1'b0;
      @(negedge clk); check("both_rsp", 32'({rsp_valid, rsp_hit}), 3);

      // Back-to-back lookups, one per cycle.
      foreach (b2b[k]) begin
         @(posedge clk); #1; lk_valid = 1'b1; lk_addr = b2b[k];
         @(negedge clk); check("b2b_rdy", 32'(lk_ready), 1);
      end
      @(posedge clk); #1; lk_valid = 1'b0;
      @(negedge clk);

      // Lookup right before a flush, second flush mid-sweep ignored, then everything misses.
      @(posedge clk); #1; lk_valid = 1'b1; lk_addr = 32'h0000_1240;
      @(negedge clk); check("pre_flush_rdy", 32'(lk_ready), 1);
      @(posedge clk); #1; lk_valid = 1'b0; flush_req = 1'b1;
      @(negedge clk);
      check("flush_cycle_rdy",  32'({lk_ready, fill_ready}), 0);
      check("flush_cycle_busy", 32'(busy), 0);
      @(posedge clk); #1; flush_req = 1'b0;
      sweep(5, -1);
      foreach (b2b[k]) lookup(b2b[k]);

      // Reset asserted with the flush sweep at index 7.
      fill(32'h0000_1240);
      @(posedge clk); #1; flush_req = 1'b1;
      @(posedge clk); #1; flush_req = 1'b0;
      sweep(-1, 7);
      rst_n = 1'b0;
      #1; check_reset("mid_rst");
      @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
      sweep(-1, -1);

      // Reset landing in a response cycle drops the response.
      fill(32'h0000_1240);
      @(posedge clk); #1; lk_valid = 1'b1; lk_addr = 32'h0000_1240;
      @(negedge clk);
      @(posedge clk); #1; lk_valid = 1'b0; rst_n = 1'b0;
      #1; check("rsp_dropped", 32'(rsp_valid), 0);
      @(negedge clk);
      @(posedge clk); #1; rst_n = 1'b1;
      sweep(-1, -1);
      lookup(32'h0000_1240);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
